// File: rtl/urv_dbus_fabric.sv
// Data-bus interconnect between the uRV data port and NSLAVE memory-mapped slaves.
// Masked base decode, per-slave wait states, error response for unmapped addresses and hung slaves.
module urv_dbus_fabric #(
    parameter int                   NSLAVE  = 4,
    // Slave i occupies BASE[16*i +: 16]: slave0=0x0000, slave1=0x1000, slave2=0x1001, slave3=0x1002.
    parameter logic [NSLAVE*16-1:0] BASE    = {16'h1002, 16'h1001, 16'h1000, 16'h0000},
    parameter logic [NSLAVE*16-1:0] MASK    = {NSLAVE{16'hFFFF}},
    parameter int                   TIMEOUT = 15
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic                 m_req,
    input  logic [31:0]          m_addr,
    input  logic [31:0]          m_wdata,
    input  logic [3:0]           m_be,
    input  logic                 m_write,
    output logic [31:0]          m_rdata,
    output logic                 m_ready,
    output logic                 m_err,
    output logic [NSLAVE-1:0]    s_sel,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_be,
    output logic                 s_write,
    input  logic [NSLAVE*32-1:0] s_rdata,
    input  logic [NSLAVE-1:0]    s_ready,
    output logic [1:0]           dbg_state_o
);

    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

    // Handshake: master raises m_req in IDLE; completion is a single m_ready pulse,
    // qualified by m_err. Slave i completes by raising s_ready[i] while s_sel[i] is high.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e              state_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;
    logic                write_q;
    logic                s_write_q;
    logic [NSLAVE-1:0]   sel_q;
    logic [31:0]         rdata_q;
    logic                ready_q;
    logic                err_q;
    logic [CW-1:0]       cnt_q;

    logic [NSLAVE-1:0]   hit_oh;
    logic                sel_ready;
    logic [31:0]         sel_rdata;

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        hit_oh = '0;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            if (((m_addr[31:16] ^ BASE[16*i +: 16]) & MASK[16*i +: 16]) == 16'h0000) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ready = |(s_ready & sel_q);
        sel_rdata = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | s_rdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            write_q   <= 1'b0;
            s_write_q <= 1'b0;
            sel_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m_req) begin
                        addr_q  <= m_addr;
                        wdata_q <= m_wdata;
                        be_q    <= m_be;
                        write_q <= m_write;
                        cnt_q   <= '0;
                        if (|hit_oh) begin
                            sel_q     <= hit_oh;
                            s_write_q <= m_write;
                            state_q   <= ACCESS;
                        end else begin
                            rdata_q <= '0;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q != TO_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // A completion in the final allowed cycle beats the timeout.
                    if (sel_ready) begin
                        rdata_q   <= write_q ? 32'h0 : sel_rdata;
                        ready_q   <= 1'b1;
                        sel_q     <= '0;
                        s_write_q <= 1'b0;
                        state_q   <= RESP;
                    end else if (cnt_q >= TO_LAST) begin
                        rdata_q   <= '0;
                        ready_q   <= 1'b1;
                        err_q     <= 1'b1;
                        sel_q     <= '0;
                        s_write_q <= 1'b0;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    sel_q     <= '0;
                    s_write_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign m_rdata     = rdata_q;
    assign m_ready     = ready_q;
    assign m_err       = err_q;
    assign s_sel       = sel_q;
    assign s_addr      = addr_q;
    assign s_wdata     = wdata_q;
    assign s_be        = be_q;
    assign s_write     = s_write_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_urv_dbus_fabric.sv
// Directed bench for urv_dbus_fabric: decode, wait states, unmapped error, timeout,
// unselected-ready rejection and asynchronous reset mid-access.
module tb_urv_dbus_fabric;

    logic         clk_i = 1'b0;
    logic         rst;
    logic         m_req;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic [3:0]   m_be;
    logic         m_write;
    logic [31:0]  m_rdata;
    logic         m_ready;
    logic         m_err;
    logic [3:0]   s_sel;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_be;
    logic         s_write;
    logic [127:0] s_rdata;
    logic [3:0]   s_ready;
    logic [1:0]   dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations returned by the driver
    int          lat;
    logic [31:0] got_rdata;
    logic        got_err;
    int          sel_cycles;
    logic [3:0]  sel_seen;
    int          wr_cycles;

    urv_dbus_fabric #(.NSLAVE(4), .TIMEOUT(15)) dut (
        .clk_i(clk_i), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_write(m_write), .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
        .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_write(s_write),
        .s_rdata(s_rdata), .s_ready(s_ready), .dbg_state_o(dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issues one access in the current cycle (cycle 0) and runs until m_ready or a 40-cycle budget.
    // Slave rdy_slave answers in ACCESS cycle waits+1; junk is driven on s_ready during the waits.
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                             input logic wr, input int rdy_slave, input int waits,
                             input logic [31:0] rdata, input logic [3:0] junk, input bit hold);
        lat = -1; got_rdata = 'x; got_err = 1'bx;
        sel_cycles = 0; sel_seen = '0; wr_cycles = 0;
        m_addr = addr; m_wdata = wdata; m_be = be; m_write = wr; m_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (!hold) m_req = 1'b0;
            s_ready = '0;
            if (m_ready) begin
                lat = c; got_rdata = m_rdata; got_err = m_err;
                break;
            end
            if (s_sel != 4'b0000) sel_cycles++;
            sel_seen = sel_seen | s_sel;
            if (s_write) wr_cycles++;
            if (rdy_slave >= 0 && c == waits + 1) begin
                s_ready[rdy_slave]          = 1'b1;
                s_rdata[32*rdy_slave +: 32] = rdata;
            end else if (c <= waits) begin
                s_ready = junk;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; m_req = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0; m_write = 1'b0;
        s_rdata = '0; s_ready = '0;
        #3;
        n_checks++; if ({m_rdata, m_ready, m_err} !== 34'h0) begin n_fail++; $display("FAIL reset_master: got %h/%b/%b want 0/0/0", m_rdata, m_ready, m_err); end
        n_checks++; if ({s_sel, s_write, s_be} !== 9'h0) begin n_fail++; $display("FAIL reset_sel_wr_be: got %b/%b/%b want 0", s_sel, s_write, s_be); end
        n_checks++; if ({s_addr, s_wdata} !== 64'h0) begin n_fail++; $display("FAIL reset_addr_wdata: got %h/%h want 0", s_addr, s_wdata); end
        n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state_o); end
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_read_zero_wait();
        do_access(32'h0000_0010, 32'h0, 4'hF, 1'b0, 0, 0, 32'hCAFE_F00D, 4'h0, 1'b0);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rd0_latency: got %0d want 2", lat); end
        n_checks++; if (got_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rd0_rdata: got %h want cafef00d", got_rdata); end
        n_checks++; if (got_err !== 1'b0) begin n_fail++; $display("FAIL rd0_err: got %b want 0", got_err); end
        n_checks++; if (sel_seen !== 4'b0001 || sel_cycles !== 1) begin n_fail++; $display("FAIL rd0_sel: got %b x%0d want 0001 x1", sel_seen, sel_cycles); end
        n_checks++; if (s_sel !== 4'b0000) begin n_fail++; $display("FAIL rd0_resp_sel: got %b want 0000", s_sel); end
        step();
        n_checks++; if (m_ready !== 1'b0 || m_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rd0_hold: got rdy=%b rdata=%h want 0/cafef00d", m_ready, m_rdata); end
    endtask

    task automatic test_unmapped();
        do_access(32'h2000_0000, 32'h0, 4'hF, 1'b0, -1, 0, 32'h0, 4'h0, 1'b0);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL unmapped_latency: got %0d want 1", lat); end
        n_checks++; if (got_err !== 1'b1 || got_rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_resp: got err=%b rdata=%h want 1/0", got_err, got_rdata); end
        n_checks++; if (s_sel !== 4'b0000) begin n_fail++; $display("FAIL unmapped_sel: got %b want 0000", s_sel); end
        step();
        n_checks++; if (m_err !== 1'b0 || m_ready !== 1'b0) begin n_fail++; $display("FAIL unmapped_after: got err=%b rdy=%b want 0/0", m_err, m_ready); end
    endtask

    task automatic test_write_waits();
        do_access(32'h1001_0004, 32'h0000_0041, 4'b0001, 1'b1, 2, 3, 32'hDEAD_BEEF, 4'h0, 1'b0);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL wr_latency: got %0d want 5", lat); end
        n_checks++; if (sel_seen !== 4'b0100 || sel_cycles !== 4) begin n_fail++; $display("FAIL wr_sel: got %b x%0d want 0100 x4", sel_seen, sel_cycles); end
        n_checks++; if (wr_cycles !== 4) begin n_fail++; $display("FAIL wr_swrite: got %0d want 4", wr_cycles); end
        n_checks++; if (s_wdata !== 32'h41 || s_addr !== 32'h1001_0004 || s_be !== 4'b0001) begin n_fail++; $display("FAIL wr_bcast: got %h/%h/%b want 41/10010004/0001", s_wdata, s_addr, s_be); end
        n_checks++; if (got_err !== 1'b0 || got_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_resp: got err=%b rdata=%h want 0/0", got_err, got_rdata); end
        n_checks++; if (s_write !== 1'b0) begin n_fail++; $display("FAIL wr_resp_swrite: got %b want 0", s_write); end
        step();
    endtask

    task automatic test_timeout();
        do_access(32'h1002_0000, 32'h0, 4'hF, 1'b0, -1, 0, 32'h0, 4'h0, 1'b0);
        n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL to_latency: got %0d want 16", lat); end
        n_checks++; if (got_err !== 1'b1 || got_rdata !== 32'h0) begin n_fail++; $display("FAIL to_resp: got err=%b rdata=%h want 1/0", got_err, got_rdata); end
        n_checks++; if (sel_seen !== 4'b1000 || sel_cycles !== 15) begin n_fail++; $display("FAIL to_sel: got %b x%0d want 1000 x15", sel_seen, sel_cycles); end
        step();
        do_access(32'h0000_0020, 32'h0, 4'hF, 1'b0, 0, 0, 32'h1234_5678, 4'h0, 1'b0);
        n_checks++; if (lat !== 2 || got_err !== 1'b0 || got_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL to_followup: got lat=%0d err=%b rdata=%h want 2/0/12345678", lat, got_err, got_rdata); end
        step();
        // Slave answers in the last allowed cycle: completion, not error
        do_access(32'h1002_0040, 32'h0, 4'hF, 1'b0, 3, 14, 32'h0BAD_F00D, 4'h0, 1'b0);
        n_checks++; if (lat !== 16 || got_err !== 1'b0 || got_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL to_coincide: got lat=%0d err=%b rdata=%h want 16/0/0badf00d", lat, got_err, got_rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        do_access(32'h1000_0008, 32'h0, 4'hF, 1'b0, 1, 2, 32'hA5A5_0001, 4'b1001, 1'b1);
        n_checks++; if (lat !== 4 || got_err !== 1'b0 || got_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL ign_resp: got lat=%0d err=%b rdata=%h want 4/0/a5a50001", lat, got_err, got_rdata); end
        n_checks++; if (sel_seen !== 4'b0010) begin n_fail++; $display("FAIL ign_sel: got %b want 0010", sel_seen); end
        step();
        n_checks++; if (s_sel !== 4'b0000 || m_ready !== 1'b0 || dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL b2b_idle: got sel=%b rdy=%b st=%0d want 0000/0/0", s_sel, m_ready, dbg_state_o); end
        step();
        n_checks++; if (s_sel !== 4'b0010) begin n_fail++; $display("FAIL b2b_restart: got %b want 0010", s_sel); end
        m_req = 1'b0;
        s_ready = 4'b0010; s_rdata[63:32] = 32'h5A5A_0002;
        step();
        s_ready = '0;
        n_checks++; if (m_ready !== 1'b1 || m_rdata !== 32'h5A5A_0002) begin n_fail++; $display("FAIL b2b_resp: got rdy=%b rdata=%h want 1/5a5a0002", m_ready, m_rdata); end
        step();
    endtask

    task automatic test_reset_mid_access();
        int seen_ready;
        seen_ready = 0;
        m_addr = 32'h1000_0000; m_wdata = 32'h77; m_be = 4'hF; m_write = 1'b1; m_req = 1'b1;
        step();
        m_req = 1'b0;
        step();
        n_checks++; if (s_sel !== 4'b0010 || s_write !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got sel=%b wr=%b want 0010/1", s_sel, s_write); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (s_sel !== 4'b0000 || s_write !== 1'b0) begin n_fail++; $display("FAIL rst_async: got sel=%b wr=%b want 0000/0", s_sel, s_write); end
        s_ready = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            if (m_ready !== 1'b0) seen_ready++;
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            s_ready = '0;
            if (m_ready !== 1'b0) seen_ready++;
        end
        n_checks++; if (seen_ready !== 0) begin n_fail++; $display("FAIL rst_no_ready: got %0d pulses want 0", seen_ready); end
        do_access(32'h1002_0000, 32'h0, 4'hF, 1'b0, 3, 0, 32'h0F0F_0F0F, 4'h0, 1'b0);
        n_checks++; if (lat !== 2 || sel_seen !== 4'b1000 || got_rdata !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL rst_after: got lat=%0d sel=%b rdata=%h want 2/1000/0f0f0f0f", lat, sel_seen, got_rdata); end
        step();
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_unmapped();
        test_write_waits();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
